sync_fifo_clearable: RTL and testbench

SYNC_FIFO_CLEARABLE -- requirements
Module: sync_fifo_clearable

---
 rtl/sync_fifo_clearable_if.sv | 31 +++
 rtl/sync_fifo_clearable.sv | 126 ++++++++++++
 tb/tb_sync_fifo_clearable.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_clearable_if.sv
// Handshake, clear and status bundle for sync_fifo_clearable.
// Handshake rule on both sides: a beat transfers on a rising clk_i edge only when valid
// and ready are both high. Once raised, valid holds with stable data until that beat transfers.
interface sync_fifo_clearable_if #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 5
);
  localparam int UW = $clog2(DEPTH + 1);

  logic          clear_i;
  logic          clear_pending_o;
  T              data_i;
  logic          valid_i;
  logic          ready_o;
  T              data_o;
  logic          valid_o;
  logic          ready_i;
  logic [UW-1:0] usage_o;
  logic          almost_full_o;
  logic [1:0]    state_o;

  modport slave (
    input  clear_i, data_i, valid_i, ready_i,
    output clear_pending_o, ready_o, data_o, valid_o, usage_o, almost_full_o, state_o
  );

  modport master (
    output clear_i, data_i, valid_i, ready_i,
    input  clear_pending_o, ready_o, data_o, valid_o, usage_o, almost_full_o, state_o
  );
endinterface

// File: rtl/sync_fifo_clearable.sv
// Synchronous FIFO with a clear sequence that either drops or drains the stored entries.
// Defining SYNC_FIFO_CLEARABLE_OUT_REG_EN adds a flushable output register that delays reads by one cycle.
module sync_fifo_clearable #(
  parameter int  WIDTH          = 8,
  parameter type T              = logic [WIDTH-1:0],
  parameter int  DEPTH          = 5,
  parameter int  DRAIN_ON_CLEAR = 0,
  parameter int  ALMOST_FULL_TH = DEPTH - 1
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  sync_fifo_clearable_if.slave bus
);
  localparam int   UW         = $clog2(DEPTH + 1);
  localparam int   PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic DRAIN_MODE = (DRAIN_ON_CLEAR != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISOLATE = 2'd1,
    DRAIN   = 2'd2,
    CLEAR   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [UW-1:0] mem_cnt_q;
  logic [UW-1:0] usage;
  logic          out_allow;
  logic          push;
  logic          mem_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Drop mode hides the output for the whole clear sequence; drain mode keeps it live until empty.
  always_comb begin
    state_d   = state_q;
    out_allow = 1'b0;
    case (state_q)
      IDLE: begin
        out_allow = 1'b1;
        if (bus.clear_i) state_d = ISOLATE;
      end
      ISOLATE: begin
        out_allow = DRAIN_MODE;
        state_d   = DRAIN_MODE ? DRAIN : CLEAR;
      end
      DRAIN: begin
        out_allow = 1'b1;
        if (usage == '0) state_d = CLEAR;
      end
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready_o         = (state_q == IDLE) && (usage < UW'(DEPTH));
  assign bus.clear_pending_o = (state_q != IDLE);
  assign bus.usage_o         = usage;
  assign bus.almost_full_o   = (int'(usage) >= ALMOST_FULL_TH);
  assign bus.state_o         = state_q;
  assign push                = bus.valid_i & bus.ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
    end else if (state_q == CLEAR) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      if (push)    wr_ptr_q <= next_ptr(wr_ptr_q);
      if (mem_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, mem_pop})
        2'b10:   mem_cnt_q <= mem_cnt_q + 1'b1;
        2'b01:   mem_cnt_q <= mem_cnt_q - 1'b1;
        default: mem_cnt_q <= mem_cnt_q;
      endcase
    end
  end

  // Storage is never reset; pointers and counter alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= bus.data_i;
  end

`ifdef SYNC_FIFO_CLEARABLE_OUT_REG_EN
  T     out_data_q;
  logic out_valid_q;
  logic pop;

  assign usage       = mem_cnt_q + UW'(out_valid_q);
  assign bus.valid_o = out_valid_q & out_allow;
  assign bus.data_o  = out_data_q;
  assign pop         = bus.valid_o & bus.ready_i;
  // Refill the output register whenever it is empty or its entry leaves this cycle.
  assign mem_pop     = out_allow && (mem_cnt_q != '0) && (!out_valid_q || bus.ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                out_valid_q <= 1'b0;
    else if (state_q == CLEAR)  out_valid_q <= 1'b0;
    else if (mem_pop)           out_valid_q <= 1'b1;
    else if (pop)               out_valid_q <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (mem_pop) out_data_q <= mem[rd_ptr_q];
  end
`else
  assign usage       = mem_cnt_q;
  assign bus.valid_o = out_allow && (mem_cnt_q != '0);
  assign bus.data_o  = mem[rd_ptr_q];
  assign mem_pop     = bus.valid_o & bus.ready_i;
`endif

endmodule

// File: tb/tb_sync_fifo_clearable.sv
// Bench for sync_fifo_clearable: a drop-mode and a drain-mode instance, DEPTH=5, WIDTH=8.
// Accepted writes enter per-instance expected queues; read beats are compared against the queue head.
module tb_sync_fifo_clearable;
`ifdef SYNC_FIFO_CLEARABLE_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  sync_fifo_clearable_if #(.T(logic [7:0]), .DEPTH(5)) bus0 ();
  sync_fifo_clearable_if #(.T(logic [7:0]), .DEPTH(5)) bus1 ();

  sync_fifo_clearable #(.WIDTH(8), .DEPTH(5), .DRAIN_ON_CLEAR(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0)
  );
  sync_fifo_clearable #(.WIDTH(8), .DEPTH(5), .DRAIN_ON_CLEAR(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge: applies inputs, reports what transfers on the next posedge, advances one cycle.
  task automatic drive(input int sel, input logic vi, input logic [7:0] di, input logic ri,
                       input logic clr, output logic pushed, output logic popped,
                       output logic [7:0] dout);
    if (sel == 0) begin
      bus0.valid_i = vi; bus0.data_i = di; bus0.ready_i = ri; bus0.clear_i = clr;
      pushed = vi & bus0.ready_o; popped = bus0.valid_o & ri; dout = bus0.data_o;
      if (pushed) exp_q0.push_back(di);
    end else begin
      bus1.valid_i = vi; bus1.data_i = di; bus1.ready_i = ri; bus1.clear_i = clr;
      pushed = vi & bus1.ready_o; popped = bus1.valid_o & ri; dout = bus1.data_o;
      if (pushed) exp_q1.push_back(di);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus0.usage_o !== 3'd0 || bus0.valid_o !== 1'b0 || bus0.clear_pending_o !== 1'b0 ||
        bus0.almost_full_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_dut0: usage=%0d valid=%b pend=%b af=%b, required 0 0 0 0",
               bus0.usage_o, bus0.valid_o, bus0.clear_pending_o, bus0.almost_full_o);
    end
    tests_run++;
    if (bus1.usage_o !== 3'd0 || bus1.valid_o !== 1'b0 || bus1.clear_pending_o !== 1'b0 ||
        bus1.almost_full_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_dut1: usage=%0d valid=%b pend=%b af=%b, required 0 0 0 0",
               bus1.usage_o, bus1.valid_o, bus1.clear_pending_o, bus1.almost_full_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus0.ready_o !== 1'b1 || bus1.ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b/%b, required 1/1", bus0.ready_o, bus1.ready_o);
    end
  endtask

  task automatic test_latency();
    logic pu, po;
    logic [7:0] d, e;
    drive(0, 1'b1, 8'h9c, 1'b0, 1'b0, pu, po, d);
    for (int k = 1; k <= 2; k++) begin
      tests_run++;
      if (bus0.valid_o !== (k >= LAT)) begin
        tests_failed++;
        $display("FAIL latency_valid cycle %0d: got %b, required %b", k, bus0.valid_o, (k >= LAT));
      end
      if (k < 2) drive(0, 1'b0, 8'h00, 1'b0, 1'b0, pu, po, d);
    end
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0, pu, po, d);
    e = exp_q0.pop_front();
    tests_run++;
    if (po !== 1'b1 || d !== e) begin
      tests_failed++;
      $display("FAIL latency_data: popped=%b data=%0h, required 1 %0h", po, d, e);
    end
  endtask

  task automatic test_fill();
    logic pu, po;
    logic [7:0] d, e;
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1'b1, 8'(i), 1'b0, 1'b0, pu, po, d);
      tests_run++;
      if (pu !== 1'b1 || int'(bus0.usage_o) != i || bus0.almost_full_o !== (i >= 4)) begin
        tests_failed++;
        $display("FAIL fill_%0d: pushed=%b usage=%0d af=%b, required 1 %0d %b",
                 i, pu, bus0.usage_o, bus0.almost_full_o, i, (i >= 4));
      end
    end
    tests_run++;
    if (bus0.ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_full_ready: got %b, required 0", bus0.ready_o);
    end
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1'b0, 8'h00, 1'b1, 1'b0, pu, po, d);
      e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 8'hxx;
      tests_run++;
      if (po !== 1'b1 || d !== e || e !== 8'(i)) begin
        tests_failed++;
        $display("FAIL fill_pop_%0d: popped=%b data=%0h, required 1 %0h", i, po, d, 8'(i));
      end
    end
    tests_run++;
    if (bus0.usage_o !== 3'd0 || bus0.valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_empty: usage=%0d valid=%b, required 0 0", bus0.usage_o, bus0.valid_o);
    end
  endtask

  task automatic test_wrap();
    logic pu, po, vi, ri;
    logic [7:0] d, e;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < 12 && cyc < 200) begin
      vi = (sent < 12) && ($urandom_range(0, 3) != 0);
      ri = 1'($urandom_range(0, 1));
      drive(0, vi, 8'(8'h10 + sent), ri, 1'b0, pu, po, d);
      if (pu) sent++;
      if (po) begin
        got++;
        e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 8'hxx;
        tests_run++;
        if (d !== e) begin
          tests_failed++;
          $display("FAIL wrap_data: got %0h, required %0h", d, e);
        end
      end
      tests_run++;
      if (int'(bus0.usage_o) != exp_q0.size() || bus0.usage_o > 3'd5 ||
          bus0.ready_o !== (exp_q0.size() < 5)) begin
        tests_failed++;
        $display("FAIL wrap_usage: usage=%0d ready=%b, required %0d %b",
                 bus0.usage_o, bus0.ready_o, exp_q0.size(), (exp_q0.size() < 5));
      end
      cyc++;
    end
    tests_run++;
    if (got != 12) begin
      tests_failed++;
      $display("FAIL wrap_count: got %0d reads, required 12", got);
    end
    bus0.valid_i = 1'b0; bus0.ready_i = 1'b0;
  endtask

  task automatic test_full_pop();
    logic pu, po;
    logic [7:0] d, e;
    for (int i = 0; i < 5; i++) drive(0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, pu, po, d);
    drive(0, 1'b1, 8'ha0, 1'b1, 1'b0, pu, po, d);
    e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 8'hxx;
    tests_run++;
    if (pu !== 1'b0 || po !== 1'b1 || d !== e || bus0.usage_o !== 3'd4) begin
      tests_failed++;
      $display("FAIL full_pop: pushed=%b popped=%b data=%0h usage=%0d, required 0 1 %0h 4",
               pu, po, d, bus0.usage_o, e);
    end
    drive(0, 1'b1, 8'ha1, 1'b0, 1'b0, pu, po, d);
    tests_run++;
    if (pu !== 1'b1 || bus0.usage_o !== 3'd5) begin
      tests_failed++;
      $display("FAIL full_repush: pushed=%b usage=%0d, required 1 5", pu, bus0.usage_o);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b0, 8'h00, 1'b1, 1'b0, pu, po, d);
      e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 8'hxx;
      tests_run++;
      if (po !== 1'b1 || d !== e) begin
        tests_failed++;
        $display("FAIL full_drain_%0d: popped=%b data=%0h, required 1 %0h", i, po, d, e);
      end
    end
  endtask

  task automatic test_drop_clear();
    logic pu, po;
    logic [7:0] d, e;
    for (int i = 0; i < 3; i++) drive(0, 1'b1, 8'(8'hc0 + i), 1'b0, 1'b0, pu, po, d);
    drive(0, 1'b0, 8'h00, 1'b0, 1'b1, pu, po, d);
    tests_run++;
    if (bus0.valid_o !== 1'b0 || bus0.clear_pending_o !== 1'b1 || bus0.ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_isolate: valid=%b pend=%b ready=%b, required 0 1 0",
               bus0.valid_o, bus0.clear_pending_o, bus0.ready_o);
    end
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0, pu, po, d);
    tests_run++;
    if (po !== 1'b0 || bus0.valid_o !== 1'b0 || bus0.clear_pending_o !== 1'b1 || bus0.ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_clear_state: popped=%b valid=%b pend=%b ready=%b, required 0 0 1 0",
               po, bus0.valid_o, bus0.clear_pending_o, bus0.ready_o);
    end
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0, pu, po, d);
    exp_q0.delete();
    tests_run++;
    if (bus0.clear_pending_o !== 1'b0 || bus0.usage_o !== 3'd0 || bus0.ready_o !== 1'b1 ||
        bus0.valid_o !== 1'b0 || po !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_done: pend=%b usage=%0d ready=%b valid=%b, required 0 0 1 0",
               bus0.clear_pending_o, bus0.usage_o, bus0.ready_o, bus0.valid_o);
    end
    drive(0, 1'b1, 8'h55, 1'b0, 1'b0, pu, po, d);
    repeat (LAT) drive(0, 1'b0, 8'h00, 1'b0, 1'b0, pu, po, d);
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0, pu, po, d);
    e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 8'hxx;
    tests_run++;
    if (po !== 1'b1 || d !== e || bus0.usage_o !== 3'd0) begin
      tests_failed++;
      $display("FAIL drop_no_stale: popped=%b data=%0h usage=%0d, required 1 %0h 0", po, d, bus0.usage_o, e);
    end
  endtask

  task automatic test_clear_held();
    logic pu, po;
    logic [7:0] d;
    logic clr_seq [6];
    logic pend_seq [6];
    clr_seq  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    pend_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b0, 8'h00, 1'b0, clr_seq[i], pu, po, d);
      tests_run++;
      if (bus0.clear_pending_o !== pend_seq[i]) begin
        tests_failed++;
        $display("FAIL clear_held_%0d: pend=%b, required %b", i, bus0.clear_pending_o, pend_seq[i]);
      end
    end
  endtask

  task automatic test_drain_clear();
    logic pu, po;
    logic [7:0] d, e;
    int cyc, pops;
    for (int i = 0; i < 3; i++) drive(1, 1'b1, 8'(8'h21 + i), 1'b0, 1'b0, pu, po, d);
    drive(1, 1'b1, 8'h24, 1'b1, 1'b1, pu, po, d);
    tests_run++;
    if (pu !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_push_on_clear: pushed=%b, required 1", pu);
    end
    pops = 0;
    if (po) begin
      pops++;
      e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 8'hxx;
      tests_run++;
      if (d !== e) begin
        tests_failed++;
        $display("FAIL drain_data: got %0h, required %0h", d, e);
      end
    end
    cyc = 0;
    while (bus1.clear_pending_o === 1'b1 && cyc < 20) begin
      tests_run++;
      if (bus1.ready_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL drain_ready: got %b, required 0", bus1.ready_o);
      end
      drive(1, 1'b1, 8'hee, 1'b1, 1'b0, pu, po, d);
      if (po) begin
        pops++;
        e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 8'hxx;
        tests_run++;
        if (d !== e) begin
          tests_failed++;
          $display("FAIL drain_data: got %0h, required %0h", d, e);
        end
      end
      cyc++;
    end
    bus1.valid_i = 1'b0; bus1.ready_i = 1'b0;
    tests_run++;
    if (cyc >= 20 || pops != 4 || exp_q1.size() != 0 || bus1.usage_o !== 3'd0 || bus1.ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_done: cycles=%0d pops=%0d left=%0d usage=%0d ready=%b, required <20 4 0 0 1",
               cyc, pops, exp_q1.size(), bus1.usage_o, bus1.ready_o);
    end
  endtask

  task automatic test_async_reset();
    logic pu, po;
    logic [7:0] d;
    for (int i = 0; i < 3; i++) drive(1, 1'b1, 8'(8'h70 + i), 1'b0, 1'b0, pu, po, d);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b1, pu, po, d);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0, pu, po, d);
    tests_run++;
    if (bus1.state_o !== 2'd2 || bus1.clear_pending_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_in_drain: state=%0d pend=%b, required 2 1", bus1.state_o, bus1.clear_pending_o);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus1.usage_o !== 3'd0 || bus1.valid_o !== 1'b0 || bus1.clear_pending_o !== 1'b0 ||
        bus1.almost_full_o !== 1'b0 || bus1.state_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL areset_immediate: usage=%0d valid=%b pend=%b af=%b state=%0d, required 0 0 0 0 0",
               bus1.usage_o, bus1.valid_o, bus1.clear_pending_o, bus1.almost_full_o, bus1.state_o);
    end
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus1.ready_o !== 1'b1 || bus1.valid_o !== 1'b0 || bus1.clear_pending_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_release: ready=%b valid=%b pend=%b, required 1 0 0",
               bus1.ready_o, bus1.valid_o, bus1.clear_pending_o);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    bus0.valid_i = 1'b0; bus0.data_i = '0; bus0.ready_i = 1'b0; bus0.clear_i = 1'b0;
    bus1.valid_i = 1'b0; bus1.data_i = '0; bus1.ready_i = 1'b0; bus1.clear_i = 1'b0;
    test_reset();
    test_latency();
    test_fill();
    test_wrap();
    test_full_pop();
    test_drop_clear();
    test_clear_held();
    test_drain_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
